// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        LOAD  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } Loader_State_t;

    localparam int unsigned LOADER_HDR_BYTES = 4;
    localparam int unsigned LOADER_SIZE      = 1024;
    localparam logic [1:0]  LOADER_LAST_LANE = 2'(LOADER_HDR_BYTES - 1);

    function automatic logic [31:0] word_to_byte_addr(input logic [31:0] idx);
        return idx << 2;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output we,
        output waddr,
        output wdata
    );

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  we,
        input  waddr,
        input  wdata
    );
endinterface

// File: rtl/imem_loader_byte_assembler.sv
// Collects four little-endian bytes into a 32-bit word; the 4th byte is
// passed straight through so the word is available on the cycle it arrives.
module imem_loader_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0]  lane_r;
    logic [23:0] low_r;

    // lane counter and lower three byte lanes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_r <= 2'd0;
            low_r  <= 24'd0;
        end else if (clear) begin
            lane_r <= 2'd0;
            low_r  <= 24'd0;
        end else if (take) begin
            lane_r <= lane_r + 2'd1;
            case (lane_r)
                2'd0:    low_r[7:0]   <= data;
                2'd1:    low_r[15:8]  <= data;
                2'd2:    low_r[23:16] <= data;
                default: low_r        <= low_r;
            endcase
        end
    end

    assign word          = {data, low_r};
    assign word_complete = take && (lane_r == LOADER_LAST_LANE);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: holds the core, reads a word-count header plus program words
// from a byte stream, writes them from address 0 upward, then releases the core.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned SIZE = LOADER_SIZE
)
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         core_hold,
    output logic         done,
    output logic         error
);

    Loader_State_t state_r;
    Loader_State_t next_state_s;

    logic        rx_ready_r;
    logic        core_hold_r;
    logic        done_r;
    logic        error_r;
    logic        we_r;
    logic [31:0] waddr_r;
    logic [31:0] wdata_r;
    logic [31:0] n_r;
    logic [31:0] k_r;

    logic        take_s;
    logic        clear_s;
    logic [31:0] word_s;
    logic        word_complete_s;
    logic        hdr_done_s;
    logic        write_s;
    logic        last_word_s;

    // rx_ready is a registered copy of "state is HDR or LOAD"
    assign take_s      = bus.rx_valid && rx_ready_r;
    assign clear_s     = (state_r == IDLE);
    assign last_word_s = ((k_r + 32'd1) == n_r);

    imem_loader_byte_assembler u_asm (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear_s),
        .take          (take_s),
        .data          (bus.rx_data),
        .word          (word_s),
        .word_complete (word_complete_s)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // next-state decode and per-cycle strobes
    always_comb begin
        next_state_s = state_r;
        hdr_done_s   = 1'b0;
        write_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = HDR;
                end else begin
                    next_state_s = IDLE;
                end
            end
            HDR: begin
                if (word_complete_s) begin
                    hdr_done_s = 1'b1;
                    if (word_s == 32'd0) begin
                        next_state_s = DONE;
                    end else if (word_s > 32'(SIZE)) begin
                        next_state_s = ERR;
                    end else begin
                        next_state_s = LOAD;
                    end
                end else begin
                    next_state_s = HDR;
                end
            end
            LOAD: begin
                if (word_complete_s) begin
                    write_s = 1'b1;
                    if (last_word_s) begin
                        next_state_s = FLUSH;
                    end else begin
                        next_state_s = LOAD;
                    end
                end else begin
                    next_state_s = LOAD;
                end
            end
            FLUSH:   next_state_s = DONE;
            DONE:    next_state_s = DONE;
            ERR:     next_state_s = ERR;
            default: next_state_s = IDLE;
        endcase
    end

    // status outputs registered from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready_r  <= 1'b0;
            core_hold_r <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            rx_ready_r  <= (next_state_s == HDR) || (next_state_s == LOAD);
            core_hold_r <= (next_state_s != DONE);
            done_r      <= (next_state_s == DONE);
            error_r     <= (next_state_s == ERR);
        end
    end

    // word count, word index and the registered write port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_r     <= 32'd0;
            k_r     <= 32'd0;
            we_r    <= 1'b0;
            waddr_r <= 32'd0;
            wdata_r <= 32'd0;
        end else begin
            we_r <= write_s;
            if (hdr_done_s) begin
                n_r <= word_s;
                k_r <= 32'd0;
            end else if (write_s) begin
                k_r     <= k_r + 32'd1;
                waddr_r <= word_to_byte_addr(k_r);
                wdata_r <= word_s;
            end
        end
    end

    assign bus.rx_ready = rx_ready_r;
    assign bus.we       = we_r;
    assign bus.waddr    = waddr_r;
    assign bus.wdata    = wdata_r;
    assign core_hold    = core_hold_r;
    assign done         = done_r;
    assign error        = error_r;

endmodule
